// File: rtl/demux8_32b_reg.sv
// Registered 1-to-8 demultiplexer with per-channel one-deep valid/ready output registers.
// Optional broadcast write to all channels when DEMUX8_BCAST_EN is defined.
module demux8_32b_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     d,
    input  logic [2:0]           s,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 bcast,
    output logic [8*WIDTH-1:0]   z,
    output logic [7:0]           z_valid,
    input  logic [7:0]           z_ready,
    output logic [CNT_W-1:0]     acc_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    logic [7:0]       ch_free;
    logic [7:0]       load;
    logic             accept;
    logic             bcast_mode;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A channel can take a word if it is empty or is being drained this cycle.
    assign ch_free = ~z_valid | z_ready;

`ifdef DEMUX8_BCAST_EN
    assign bcast_mode = bcast;
`else
    logic unused_bcast;
    assign unused_bcast = bcast;
    assign bcast_mode   = 1'b0;
`endif

    always_comb begin
        in_ready = bcast_mode ? (&ch_free) : ch_free[s];
        accept   = in_valid & in_ready;
        load     = '0;
        if (accept) begin
            if (bcast_mode) begin
                load = '1;
            end else begin
                load[s] = 1'b1;
            end
        end
        cnt_d = accept ? (cnt_q + CNT_W'(1)) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign acc_cnt = cnt_q;

    for (genvar gi = 0; gi < 8; gi++) begin : g_chan
        chan_state_t      state_q;
        chan_state_t      state_d;
        logic [WIDTH-1:0] data_q;
        logic [WIDTH-1:0] data_d;

        // A load beats a simultaneous drain so one channel can stream at full rate.
        always_comb begin
            state_d = state_q;
            data_d  = data_q;
            if (load[gi]) begin
                state_d = FULL;
                data_d  = d;
            end else if (state_q == FULL && z_ready[gi]) begin
                state_d = EMPTY;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= EMPTY;
                data_q  <= '0;
            end else begin
                state_q <= state_d;
                data_q  <= data_d;
            end
        end

        assign z[gi*WIDTH +: WIDTH] = data_q;
        assign z_valid[gi]          = (state_q == FULL);
    end

endmodule

// File: tb/tb_demux8_32b_reg.sv
// Self-checking bench for demux8_32b_reg: directed steps plus random traffic
// compared against an array-based reference model of the channel rules.
module tb_demux8_32b_reg;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  d;
    logic [2:0]   s;
    logic         in_valid;
    logic         in_ready;
    logic         bcast;
    logic [255:0] z;
    logic [7:0]   z_valid;
    logic [7:0]   z_ready;
    logic [15:0]  acc_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_data [8];
    bit          m_valid [8];
    int          m_cnt;
    bit          last_acc;

    demux8_32b_reg dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (d),
        .s        (s),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bcast    (bcast),
        .z        (z),
        .z_valid  (z_valid),
        .z_ready  (z_ready),
        .acc_cnt  (acc_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit bcast_on();
`ifdef DEMUX8_BCAST_EN
        return bcast;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_ready();
        bit r;
        if (bcast_on()) begin
            r = 1'b1;
            for (int i = 0; i < 8; i++)
                if (m_valid[i] && !z_ready[i]) r = 1'b0;
        end else begin
            r = !m_valid[s] || z_ready[s];
        end
        return r;
    endfunction

    function automatic logic [255:0] model_z();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = m_data[i];
        return v;
    endfunction

    function automatic logic [7:0] model_zv();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_valid[i];
        return v;
    endfunction

    // Apply one clock edge's worth of behaviour to the model using current inputs.
    task automatic model_step();
        bit acc;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                m_data[i]  = '0;
                m_valid[i] = 1'b0;
            end
            m_cnt    = 0;
            last_acc = 1'b0;
        end else begin
            acc = in_valid && model_ready();
            for (int i = 0; i < 8; i++) begin
                if (acc && (bcast_on() || int'(s) == i)) begin
                    m_data[i]  = d;
                    m_valid[i] = 1'b1;
                end else if (m_valid[i] && z_ready[i]) begin
                    m_valid[i] = 1'b0;
                end
            end
            if (acc) m_cnt = (m_cnt + 1) % 65536;
            last_acc = acc;
        end
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clocked transaction: check comb ready, clock, then check registered outputs.
    task automatic cycle(input string tag, input bit verbose = 1'b1);
        #1;
        if (rst_n) check({tag, ".in_ready"}, 256'(in_ready), 256'(model_ready()));
        @(posedge clk);
        model_step();
        #1;
        check({tag, ".z_valid"}, 256'(z_valid), 256'(model_zv()));
        check({tag, ".z"}, z, model_z());
        check({tag, ".acc_cnt"}, 256'(acc_cnt), 256'(m_cnt));
        if (verbose)
            $display("%s rst_n=%b s=%0d d=%h bc=%b vld=%b acc=%b zr=%h -> zv=%h cnt=%0d",
                     tag, rst_n, s, d, bcast, in_valid, last_acc, z_ready, z_valid, acc_cnt);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_data[i]  = '0;
            m_valid[i] = 1'b0;
        end
        m_cnt    = 0;
        last_acc = 1'b0;

        // Reset held two cycles with traffic present
        rst_n = 1'b0; in_valid = 1'b1; s = 3'd4; d = 32'hCAFEF00D; bcast = 1'b0; z_ready = 8'hFF;
        @(posedge clk);
        cycle("reset0");
        cycle("reset1");
        check("reset.z_valid_const", 256'(z_valid), 256'(8'h00));
        check("reset.acc_cnt_const", 256'(acc_cnt), 256'(16'h0000));
        rst_n = 1'b1; in_valid = 1'b0; z_ready = 8'h00;
        #1;
        check("reset.in_ready_after", 256'(in_ready), 256'(1'b1));
        cycle("idle");

        // Walk all selects with no consumers draining
        for (int i = 0; i < 8; i++) begin
            s = 3'(i); d = 32'(i) * 32'h11111111; in_valid = 1'b1;
            cycle($sformatf("walk%0d", i));
        end
        check("walk.z_valid_const", 256'(z_valid), 256'(8'hFF));
        check("walk.acc_cnt_const", 256'(acc_cnt), 256'(16'd8));
        check("walk.z7_const", 256'(z[7*32 +: 32]), 256'(32'h77777777));

        // Backpressure on a full channel, then release
        s = 3'd3; d = 32'hDEADBEEF; in_valid = 1'b1; z_ready = 8'h00;
        #1;
        check("bp.in_ready_low", 256'(in_ready), 256'(1'b0));
        cycle("bp_stall");
        check("bp.z3_held", 256'(z[3*32 +: 32]), 256'(32'h33333333));
        z_ready = 8'h08;
        cycle("bp_release");
        check("bp.z3_new", 256'(z[3*32 +: 32]), 256'(32'hDEADBEEF));
        check("bp.zv3", 256'(z_valid[3]), 256'(1'b1));

        // Streaming on channel 5 with its consumer always ready
        s = 3'd5; z_ready = 8'h20;
        for (int i = 0; i < 4; i++) begin
            d = 32'hA0A0A0A0 + 32'(i);
            cycle($sformatf("stream%0d", i));
            check($sformatf("stream%0d.z5", i), 256'(z[5*32 +: 32]), 256'(32'hA0A0A0A0 + 32'(i)));
        end

        // Random traffic; stalled requests are held stable
        for (int n = 0; n < 300; n++) begin
            if (!(in_valid && !last_acc)) begin
                s     = 3'($urandom_range(0, 7));
                d     = $urandom;
                bcast = 1'($urandom_range(0, 1));
            end
            in_valid = ($urandom_range(0, 3) != 0);
            z_ready  = 8'($urandom);
            cycle($sformatf("rand%0d", n), 1'b0);
        end

        // Counter wrap: stream into channel 0 until the count reaches 0xFFFF
        bcast = 1'b0; s = 3'd0; z_ready = 8'hFF; in_valid = 1'b1; d = 32'h0BADF00D;
        while (m_cnt != 65535) begin
            @(posedge clk);
            model_step();
        end
        #1;
        check("wrap.acc_cnt_ffff", 256'(acc_cnt), 256'(16'hFFFF));
        d = 32'h00C0FFEE;
        cycle("wrap_last");
        check("wrap.acc_cnt_zero", 256'(acc_cnt), 256'(16'h0000));

        // Broadcast request with all channels empty
        in_valid = 1'b0; z_ready = 8'hFF;
        cycle("drain_all");
        check("drain.z_valid", 256'(z_valid), 256'(8'h00));
        bcast = 1'b1; s = 3'd2; d = 32'h12345678; z_ready = 8'h00; in_valid = 1'b1;
        cycle("bcast");
        in_valid = 1'b0; bcast = 1'b0;
`ifdef DEMUX8_BCAST_EN
        check("bcast.z_valid", 256'(z_valid), 256'(8'hFF));
        check("bcast.z", z, {8{32'h12345678}});
`else
        check("bcast.z_valid", 256'(z_valid), 256'(8'h04));
        check("bcast.z2", 256'(z[2*32 +: 32]), 256'(32'h12345678));
`endif
        check("bcast.acc_cnt", 256'(acc_cnt), 256'(16'd1));
        cycle("final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
